// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state definitions for the jk_seq_ctrl block.
package jk_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_NOP        = 3'd0,
        OP_LOAD       = 3'd1,
        OP_CLEAR      = 3'd2,
        OP_SET        = 3'd3,
        OP_TOGGLE     = 3'd4,
        OP_COUNT_UP   = 3'd5,
        OP_COUNT_DOWN = 3'd6,
        OP_RSVD       = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        COUNT = 2'd2
    } state_e;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset (q=0, qb=1).
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q  <= 1'b0;
            qb <= 1'b1;
        end else begin
            case ({j, k})
                2'b01: begin q <= 1'b0; qb <= 1'b1; end
                2'b10: begin q <= 1'b1; qb <= 1'b0; end
                2'b11: begin q <= qb;   qb <= q;    end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/jk_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit bank of JK cells.
// Optional JK_SEQ_ERR_EN adds a sticky err flag for the reserved opcode.
module jk_seq_ctrl
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OP_W-1:0]  cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] q,
`ifdef JK_SEQ_ERR_EN
    output logic             err,
`endif
    output logic             busy,
    output logic             done
);

    state_e             state, state_nxt;
    op_e                op_r;
    logic [WIDTH-1:0]   data_r;
    logic [CNT_W-1:0]   rem;
    logic [WIDTH-1:0]   qb, j, k, up_t, dn_t;
    logic               accept, is_count, len_zero;

    assign cmd_ready = (state == IDLE) & ~rst;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid & cmd_ready;
    assign is_count  = (cmd_op == OP_COUNT_UP) || (cmd_op == OP_COUNT_DOWN);
    assign len_zero  = (cmd_len == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = (is_count && !len_zero) ? COUNT : EXEC;
            EXEC:    state_nxt = IDLE;
            COUNT:   if (rem == CNT_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_r   <= OP_NOP;
            data_r <= '0;
            rem    <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= (state == EXEC) || (state == COUNT && rem == CNT_W'(1));
            if (accept) begin
                // A zero-length count is captured as NOP so EXEC drives nothing
                op_r   <= (is_count && len_zero) ? OP_NOP : op_e'(cmd_op);
                data_r <= cmd_data;
                rem    <= cmd_len;
            end else if (state == COUNT) begin
                rem <= rem - CNT_W'(1);
            end
        end
    end

`ifdef JK_SEQ_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)         err <= 1'b0;
        else if (accept) err <= (cmd_op == OP_RSVD);
    end
`endif

    // Ripple-carry/borrow toggle enables for synchronous counting
    always_comb begin
        logic acc_u, acc_d;
        acc_u = 1'b1;
        acc_d = 1'b1;
        up_t  = '0;
        dn_t  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            up_t[i] = acc_u;
            dn_t[i] = acc_d;
            acc_u   = acc_u & q[i];
            acc_d   = acc_d & qb[i];
        end
    end

    always_comb begin
        j = '0;
        k = '0;
        if (state != IDLE) begin
            case (op_r)
                OP_LOAD:       begin j = data_r; k = ~data_r; end
                OP_CLEAR:      k = data_r;
                OP_SET:        j = data_r;
                OP_TOGGLE:     begin j = data_r; k = data_r; end
                OP_COUNT_UP:   begin j = up_t;   k = up_t;   end
                OP_COUNT_DOWN: begin j = dn_t;   k = dn_t;   end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j[i]),
            .k   (k[i]),
            .q   (q[i]),
            .qb  (qb[i])
        );
    end

endmodule

// File: tb/tb_jk_seq_ctrl.sv
// Directed self-checking bench for jk_seq_ctrl (WIDTH=8).
module tb_jk_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_data = 8'h00;
    logic [7:0] cmd_len = 8'h00;
    logic [7:0] q;
    logic       busy, done;
`ifdef JK_SEQ_ERR_EN
    logic       err;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    jk_seq_ctrl #(.WIDTH(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .q         (q),
`ifdef JK_SEQ_ERR_EN
        .err       (err),
`endif
        .busy      (busy),
        .done      (done)
    );

    // Present a command for one edge; returns in the cycle after acceptance
    task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] len);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (q !== 8'h00) $display("FAIL reset_q got %h want 00", q); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", cmd_ready); else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL release_ready got %b want 1", cmd_ready); else pass_cnt++;
    endtask

    task automatic test_load;
        send(3'd1, 8'hA5, 8'd0);
        total++; if (cmd_ready !== 1'b0) $display("FAIL load_ready_low got %b want 0", cmd_ready); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL load_busy got %b want 1", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL load_done_early got %b want 0", done); else pass_cnt++;
        @(negedge clk);
        total++; if (q !== 8'hA5) $display("FAIL load_q got %h want a5", q); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL load_done got %b want 1", done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL load_busy_end got %b want 0", busy); else pass_cnt++;
        total++; if (cmd_ready !== 1'b1) $display("FAIL load_ready_back got %b want 1", cmd_ready); else pass_cnt++;
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL load_done_pulse got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_masked;
        logic [2:0] ops [4]  = '{3'd4, 3'd3, 3'd2, 3'd0};
        logic [7:0] dat [4]  = '{8'h0F, 8'h50, 8'h82, 8'hFF};
        logic [7:0] exp [4]  = '{8'hAA, 8'hFA, 8'h78, 8'h78};
        for (int i = 0; i < 4; i++) begin
            send(ops[i], dat[i], 8'd0);
            @(negedge clk);
            total++; if (q !== exp[i]) $display("FAIL masked_q[%0d] got %h want %h", i, q, exp[i]); else pass_cnt++;
            total++; if (done !== 1'b1) $display("FAIL masked_done[%0d] got %b want 1", i, done); else pass_cnt++;
        end
    endtask

    task automatic test_count_up;
        logic [7:0] exp [5] = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
        send(3'd1, 8'hFD, 8'd0);
        @(negedge clk);
        send(3'd5, 8'h00, 8'd5);
        total++; if (busy !== 1'b1) $display("FAIL up_busy_start got %b want 1", busy); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (q !== exp[i]) $display("FAIL up_q[%0d] got %h want %h", i, q, exp[i]); else pass_cnt++;
            total++; if (busy !== (i < 4)) $display("FAIL up_busy[%0d] got %b want %b", i, busy, (i < 4)); else pass_cnt++;
            total++; if (done !== (i == 4)) $display("FAIL up_done[%0d] got %b want %b", i, done, (i == 4)); else pass_cnt++;
        end
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL up_done_pulse got %b want 0", done); else pass_cnt++;
    endtask

    task automatic test_count_down;
        logic [7:0] exp [3] = '{8'h00, 8'hFF, 8'hFE};
        send(3'd1, 8'h01, 8'd0);
        @(negedge clk);
        send(3'd6, 8'h00, 8'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (q !== exp[i]) $display("FAIL down_q[%0d] got %h want %h", i, q, exp[i]); else pass_cnt++;
        end
        total++; if (done !== 1'b1) $display("FAIL down_done got %b want 1", done); else pass_cnt++;
        send(3'd5, 8'h00, 8'd0);
        total++; if (busy !== 1'b1) $display("FAIL len0_busy got %b want 1", busy); else pass_cnt++;
        @(negedge clk);
        total++; if (q !== 8'hFE) $display("FAIL len0_q got %h want fe", q); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL len0_done got %b want 1", done); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL len0_busy_end got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid_count;
        send(3'd1, 8'h00, 8'd0);
        @(negedge clk);
        send(3'd5, 8'h00, 8'd10);
        repeat (4) @(negedge clk);
        total++; if (q !== 8'h04) $display("FAIL mid_q got %h want 04", q); else pass_cnt++;
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_data = 8'h33; cmd_len = 8'd0;
        @(negedge clk);
        total++; if (q !== 8'h00) $display("FAIL mid_rst_q got %h want 00", q); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL mid_rst_done got %b want 0", done); else pass_cnt++;
        total++; if (cmd_ready !== 1'b0) $display("FAIL mid_rst_ready got %b want 0", cmd_ready); else pass_cnt++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_hold_busy got %b want 0", busy); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL mid_rst_hold_done got %b want 0", done); else pass_cnt++;
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) $display("FAIL mid_rel_ready got %b want 1", cmd_ready); else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (busy !== 1'b1) $display("FAIL held_busy got %b want 1", busy); else pass_cnt++;
        total++; if (q !== 8'h00) $display("FAIL held_q_pre got %h want 00", q); else pass_cnt++;
        @(negedge clk);
        total++; if (q !== 8'h33) $display("FAIL held_q got %h want 33", q); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL held_done got %b want 1", done); else pass_cnt++;
    endtask

    task automatic test_rsvd;
        send(3'd7, 8'hFF, 8'd0);
        @(negedge clk);
        total++; if (q !== 8'h33) $display("FAIL rsvd_q got %h want 33", q); else pass_cnt++;
        total++; if (done !== 1'b1) $display("FAIL rsvd_done got %b want 1", done); else pass_cnt++;
`ifdef JK_SEQ_ERR_EN
        total++; if (err !== 1'b1) $display("FAIL rsvd_err got %b want 1", err); else pass_cnt++;
`endif
        @(negedge clk);
        total++; if (done !== 1'b0) $display("FAIL rsvd_done_pulse got %b want 0", done); else pass_cnt++;
`ifdef JK_SEQ_ERR_EN
        total++; if (err !== 1'b1) $display("FAIL rsvd_err_sticky got %b want 1", err); else pass_cnt++;
`endif
        send(3'd1, 8'h3C, 8'd0);
`ifdef JK_SEQ_ERR_EN
        total++; if (err !== 1'b0) $display("FAIL rsvd_err_clear got %b want 0", err); else pass_cnt++;
`endif
        @(negedge clk);
        total++; if (q !== 8'h3C) $display("FAIL rsvd_load_q got %h want 3c", q); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_masked();
        test_count_up();
        test_count_down();
        test_reset_mid_count();
        test_rsvd();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
